// File: rtl/uart_rx_fifo_ctl_pkg.sv
// Shared constants for the UART receive controller.
// Parity modes and receive FSM state encodings.
package uart_rx_fifo_ctl_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_ctl_sync_fifo.sv
// Show-ahead synchronous FIFO.
// A pop and a push in one cycle both happen, even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             rd_en, wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rptr_q];

  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo_ctl.sv
// Oversampling UART receiver with parity/frame checks,
// sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo_ctl
  import uart_rx_fifo_ctl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int OVS        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bclk,
  input  logic                          rx,
  input  logic                          rd,
  output logic [DATA_W-1:0]             dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] T_HALF = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam bit P_ODD = (PARITY == PARITY_ODD);
  localparam bit P_ON  = (PARITY != PARITY_NONE);

  logic              rx_m_q, rx_s_q;
  rx_state_e         state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pflag_q, pflag_d;
  logic              fe_q, fe_d;
  logic              pe_q, pe_d;
  logic              ov_q, ov_d;
  logic              par_exp;
  logic              stop_smp;
  logic              push;
  logic              set_fe, set_pe, set_ov;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      pflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      pflag_q <= pflag_d;
    end
  end

  assign par_exp = (^shreg_q) ^ P_ODD;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    pflag_d = pflag_q;
    if (bclk) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            tcnt_d  = TW'(1);
            pflag_d = 1'b0;
          end
        end
        ST_START: begin
          if (tcnt_q == T_HALF) begin
            // A high line at mid start bit is a glitch
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_W-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = P_ON ? ST_PAR : ST_STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_PAR: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            pflag_d = (rx_s_q != par_exp);
            state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    stop_smp = (state_q == ST_STOP) & bclk
             & (tcnt_q == T_LAST);
  end

  assign set_fe = stop_smp & ~rx_s_q;
  assign set_pe = stop_smp & rx_s_q & pflag_q;
  assign push   = stop_smp & rx_s_q & ~pflag_q;
  // A same-cycle pop frees a slot, so no overrun then
  assign set_ov = push & full & ~rd;

  assign fe_d = set_fe | (fe_q & ~err_clr);
  assign pe_d = set_pe | (pe_q & ~err_clr);
  assign ov_d = set_ov | (ov_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_q <= 1'b0;
      pe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
      pe_q <= pe_d;
      ov_q <= ov_d;
    end
  end

  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ov_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .din   (shreg_q),
    .rd    (rd),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo_ctl.sv
// Bench for uart_rx_fifo_ctl: three instances, one per parity mode,
// with a per-instance queue of expected received words.
module tb_uart_rx_fifo_ctl;

  localparam int OVS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic err_clr = 1'b0;
  int   cyc = 0;

  logic       rx_w    [3];
  logic       rd_w    [3];
  logic [7:0] dout_w  [3];
  logic       empty_w [3];
  logic       full_w  [3];
  logic [4:0] cnt_w   [3];
  logic       busy_w  [3];
  logic       fe_w    [3];
  logic       pe_w    [3];
  logic       ov_w    [3];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : gd
    uart_rx_fifo_ctl #(
      .DATA_W(8), .FIFO_DEPTH(16),
      .PARITY(g), .OVS(OVS)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bclk       (bclk),
      .rx         (rx_w[g]),
      .rd         (rd_w[g]),
      .dout       (dout_w[g]),
      .empty      (empty_w[g]),
      .full       (full_w[g]),
      .count      (cnt_w[g]),
      .busy       (busy_w[g]),
      .frame_err  (fe_w[g]),
      .parity_err (pe_w[g]),
      .overrun    (ov_w[g]),
      .err_clr    (err_clr)
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      bclk = ~bclk;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int w, input logic [7:0] d);
    case (w)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  function automatic logic [7:0] pop_exp(input int w);
    logic [7:0] v;
    v = 'x;
    case (w)
      0:       if (q0.size() > 0) v = q0.pop_front();
      1:       if (q1.size() > 0) v = q1.pop_front();
      default: if (q2.size() > 0) v = q2.pop_front();
    endcase
    return v;
  endfunction

  task automatic align();
    if (cyc[0]) @(negedge clk);
  endtask

  task automatic send_bit(input int w, input logic v, input int ticks);
    rx_w[w] = v;
    repeat (2 * ticks) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d,
                            input logic has_par, input logic pbit,
                            input logic bad_stop);
    align();
    send_bit(w, 1'b0, OVS);
    for (int i = 0; i < 8; i++) send_bit(w, d[i], OVS);
    if (has_par) send_bit(w, pbit, OVS);
    if (bad_stop) begin
      send_bit(w, 1'b0, 9);
      send_bit(w, 1'b1, OVS - 9);
    end else begin
      send_bit(w, 1'b1, OVS);
    end
  endtask

  task automatic pop_check(input int w, input string tag);
    int t;
    t = 0;
    while (empty_w[w] && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (empty_w[w]) begin
      chk({tag, "_wait"}, empty_w[w], 1'b0);
    end else begin
      chk(tag, dout_w[w], pop_exp(w));
      rd_w[w] = 1'b1;
      @(negedge clk);
      rd_w[w] = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic flags_zero(input int w, input string tag);
    chk(tag, {fe_w[w], pe_w[w], ov_w[w]}, 3'b000);
  endtask

  int  off;
  int  s0;
  int  t0;
  bit  saw;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_w[i] = 1'b1;
      rd_w[i] = 1'b0;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", empty_w[0], 1'b1);
    chk("rst_full", full_w[0], 1'b0);
    chk("rst_count", cnt_w[0], 5'd0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_dout", dout_w[0], 8'h00);
    flags_zero(0, "rst_flags");

    // single word, no parity
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    push_exp(0, 8'hA5);
    repeat (2) @(negedge clk);
    chk("a5_empty", empty_w[0], 1'b0);
    chk("a5_count", cnt_w[0], 5'd1);
    pop_check(0, "a5_dout");
    chk("a5_empty_after", empty_w[0], 1'b1);
    flags_zero(0, "a5_flags");

    // even parity: wrong then right
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("par_err", pe_w[1], 1'b1);
    chk("par_fe", fe_w[1], 1'b0);
    chk("par_empty", empty_w[1], 1'b1);
    pulse_clr();
    chk("par_clr", pe_w[1], 1'b0);
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b0);
    push_exp(1, 8'h3C);
    pop_check(1, "par_ok_dout");
    flags_zero(1, "par_ok_flags");

    // frame error, then frame error beating parity error
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("fe_set", fe_w[0], 1'b1);
    chk("fe_pe", pe_w[0], 1'b0);
    chk("fe_empty", empty_w[0], 1'b1);
    send_frame(2, 8'h55, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("fe2_set", fe_w[2], 1'b1);
    chk("fe2_pe", pe_w[2], 1'b0);
    chk("fe2_empty", empty_w[2], 1'b1);
    pulse_clr();
    chk("fe_clr", fe_w[0], 1'b0);

    // fill past full with no reads
    for (int i = 0; i < 15; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b0, 1'b0);
      push_exp(0, 8'(i));
    end
    align();
    off = 0;
    fork
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0);
      begin
        s0 = cyc;
        t0 = 0;
        while (!full_w[0] && t0 < 400) begin
          @(negedge clk);
          t0++;
        end
        off = cyc - s0;
      end
    join
    push_exp(0, 8'h0F);
    chk("fill_full", full_w[0], 1'b1);
    chk("fill_count", cnt_w[0], 5'd16);
    chk("fill_ov0", ov_w[0], 1'b0);
    send_frame(0, 8'h10, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("ovr_set", ov_w[0], 1'b1);
    chk("ovr_count", cnt_w[0], 5'd16);
    for (int i = 0; i < 16; i++) pop_check(0, "fill_pop");
    chk("fill_empty", empty_w[0], 1'b1);
    pulse_clr();
    chk("ovr_clr", ov_w[0], 1'b0);

    // same again, with a pop on the 17th push cycle
    for (int i = 0; i < 16; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b0, 1'b0);
      push_exp(0, 8'(i));
    end
    align();
    fork
      send_frame(0, 8'h10, 1'b0, 1'b0, 1'b0);
      begin
        s0 = cyc;
        t0 = 0;
        while (cyc != s0 + off - 1 && t0 < 400) begin
          @(negedge clk);
          t0++;
        end
        chk("rdw_head", dout_w[0], pop_exp(0));
        rd_w[0] = 1'b1;
        @(negedge clk);
        rd_w[0] = 1'b0;
      end
    join
    push_exp(0, 8'h10);
    repeat (2) @(negedge clk);
    chk("rdw_ov", ov_w[0], 1'b0);
    chk("rdw_count", cnt_w[0], 5'd16);
    chk("rdw_full", full_w[0], 1'b1);
    for (int i = 0; i < 16; i++) pop_check(0, "rdw_pop");
    chk("rdw_empty", empty_w[0], 1'b1);

    // short low glitch on the line
    align();
    saw = 1'b0;
    fork
      begin
        rx_w[0] = 1'b0;
        repeat (8) @(negedge clk);
        rx_w[0] = 1'b1;
        repeat (40) @(negedge clk);
      end
      begin
        repeat (48) begin
          @(negedge clk);
          if (busy_w[0]) saw = 1'b1;
        end
      end
    join
    chk("gl_busy_seen", saw, 1'b1);
    chk("gl_busy_end", busy_w[0], 1'b0);
    chk("gl_empty", empty_w[0], 1'b1);
    flags_zero(0, "gl_flags");
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    push_exp(0, 8'h5A);
    pop_check(0, "gl_next");

    // reset in the middle of a frame
    align();
    send_bit(0, 1'b0, OVS);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, OVS);
    chk("mr_busy_pre", busy_w[0], 1'b1);
    rst = 1'b1;
    rx_w[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy_w[0], 1'b0);
    chk("mr_empty", empty_w[0], 1'b1);
    flags_zero(0, "mr_flags");
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    push_exp(0, 8'h81);
    pop_check(0, "mr_next");
    chk("mr_end_empty", empty_w[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
